// File: rtl/hpdl_write_sequencer_pkg.sv
// Shared definitions for the HPDL-1414 write sequencer: FSM encoding,
// control-character constants and the display character-set folding.
package hpdl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_SETUP  = 3'd2;
    localparam state_t ST_PULSE  = 3'd3;
    localparam state_t ST_HOLD   = 3'd4;
    localparam state_t ST_CLEAR  = 3'd5;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_QMARK = 8'h3F;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;

    // Returns {write_flag, code}; the displays only have glyphs for 0x20..0x5F.
    function automatic logic [7:0] map_char(input logic [7:0] b);
        logic [7:0] res;
        if (b >= 8'h80) begin
            res = {1'b1, CH_QMARK[6:0]};
        end else if (b >= 8'h60) begin
            res = {1'b1, 7'(b - 8'h20)};
        end else if (b >= 8'h20) begin
            res = {1'b1, b[6:0]};
        end else begin
            res = {1'b0, b[6:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/hpdl_write_sequencer.sv
// Turns a byte stream into timed write cycles on four chained HPDL-1414
// displays, handling cursor movement, clear-screen and character folding.
module hpdl_write_sequencer
    import hpdl_pkg::*;
#(
    parameter int SETUP_CYC      = 1,
    parameter int PULSE_CYC      = 2,
    parameter int HOLD_CYC       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic       CLK_i,
    input  logic       RST_i,
    input  logic [7:0] char_i,
    input  logic       char_valid_i,
    output logic       char_ready_o,
    output logic [6:0] hpdl_d_o,
    output logic [1:0] hpdl_a_o,
    output logic [3:0] hpdl_wr_n_o,
    output logic [3:0] cursor_o,
    output logic       busy_o
);

    localparam int CNT_W = 8;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       char_q, char_d;
    logic [1:0]       chip_q, chip_d;
    logic [3:0]       clr_idx_q, clr_idx_d;
    logic             clr_active_q, clr_active_d;
    logic             clear_pend_q, clear_pend_d;
    logic [3:0]       cursor_q, cursor_d;
    logic [6:0]       d_q, d_d;
    logic [1:0]       a_q, a_d;
    logic [3:0]       wr_n_q, wr_n_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic [7:0]       mapped_s;

    assign mapped_s = map_char(char_q);

    // Next-state logic; outputs are derived from the next state so they leave flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        char_d       = char_q;
        chip_d       = chip_q;
        clr_idx_d    = clr_idx_q;
        clr_active_d = clr_active_q;
        clear_pend_d = clear_pend_q;
        cursor_d     = cursor_q;
        d_d          = d_q;
        a_d          = a_q;

        case (state_q)
            ST_IDLE: begin
                if (clear_pend_q) begin
                    clear_pend_d = 1'b0;
                    clr_idx_d    = 4'd0;
                    state_d      = ST_CLEAR;
                end else if (char_valid_i && ready_q) begin
                    char_d  = char_i;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (mapped_s[7]) begin
                    d_d     = mapped_s[6:0];
                    a_d     = 2'd3 - cursor_q[1:0];
                    chip_d  = cursor_q[3:2];
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = ST_SETUP;
                end else if (char_q == CH_CR) begin
                    cursor_d = 4'd0;
                    state_d  = ST_IDLE;
                end else if (char_q == CH_BS) begin
                    cursor_d = cursor_q - 4'd1;
                    state_d  = ST_IDLE;
                end else if (char_q == CH_FF) begin
                    cursor_d  = 4'd0;
                    clr_idx_d = 4'd0;
                    state_d   = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_active_d = 1'b1;
                d_d          = CH_SPACE[6:0];
                a_d          = 2'd3 - clr_idx_q[1:0];
                chip_d       = clr_idx_q[3:2];
                cnt_d        = CNT_W'(SETUP_CYC - 1);
                state_d      = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cursor_d = cursor_q + 4'd1;
                    if (!clr_active_q) begin
                        state_d = ST_IDLE;
                    end else if (clr_idx_q == 4'd15) begin
                        clr_active_d = 1'b0;
                        cursor_d     = 4'd0;
                        state_d      = ST_IDLE;
                    end else begin
                        clr_idx_d = clr_idx_q + 4'd1;
                        state_d   = ST_CLEAR;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_PULSE) begin
            wr_n_d         = 4'b1111;
            wr_n_d[chip_d] = 1'b0;
        end else begin
            wr_n_d = 4'b1111;
        end
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            char_q       <= 8'h00;
            chip_q       <= 2'd0;
            clr_idx_q    <= 4'd0;
            clr_active_q <= 1'b0;
            clear_pend_q <= (CLEAR_ON_RESET != 0);
            cursor_q     <= 4'd0;
            d_q          <= CH_SPACE[6:0];
            a_q          <= 2'd0;
            wr_n_q       <= 4'b1111;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            char_q       <= char_d;
            chip_q       <= chip_d;
            clr_idx_q    <= clr_idx_d;
            clr_active_q <= clr_active_d;
            clear_pend_q <= clear_pend_d;
            cursor_q     <= cursor_d;
            d_q          <= d_d;
            a_q          <= a_d;
            wr_n_q       <= wr_n_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign char_ready_o = ready_q;
    assign hpdl_d_o     = d_q;
    assign hpdl_a_o     = a_q;
    assign hpdl_wr_n_o  = wr_n_q;
    assign cursor_o     = cursor_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_hpdl_write_sequencer.sv
// Bench for hpdl_write_sequencer: a frame-schedule model predicts every output
// cycle by cycle; directed sequences plus random bytes drive the design.
module tb_hpdl_write_sequencer;

    logic       CLK_i = 1'b0;
    logic       RST_i = 1'b1;
    logic [7:0] char_i = 8'h00;
    logic       char_valid_i = 1'b0;
    logic       char_ready_o;
    logic [6:0] hpdl_d_o;
    logic [1:0] hpdl_a_o;
    logic [3:0] hpdl_wr_n_o;
    logic [3:0] cursor_o;
    logic       busy_o;

    always #5 CLK_i = ~CLK_i;

    hpdl_write_sequencer dut (
        .CLK_i(CLK_i), .RST_i(RST_i), .char_i(char_i), .char_valid_i(char_valid_i),
        .char_ready_o(char_ready_o), .hpdl_d_o(hpdl_d_o), .hpdl_a_o(hpdl_a_o),
        .hpdl_wr_n_o(hpdl_wr_n_o), .cursor_o(cursor_o), .busy_o(busy_o)
    );

    localparam int MAXF = 8192;

    // Expected outputs per frame (frame k = values just after clock edge k).
    int exp_ready[MAXF];
    int exp_busy[MAXF];
    int exp_wr[MAXF];
    int exp_d[MAXF];
    int exp_a[MAXF];
    int exp_cur[MAXF];
    bit chk_da[MAXF];
    bit chk_cur[MAXF];

    int f = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit pend_clear = 1'b0;
    int m_cursor = 0;
    bit acc_flag = 1'b0;

    task automatic set_idle(input int i);
        exp_ready[i] = 1; exp_busy[i] = 0; exp_wr[i] = 15;
        chk_da[i] = 1'b0; chk_cur[i] = 1'b0;
    endtask

    task automatic set_busy(input int i);
        exp_ready[i] = 0; exp_busy[i] = 1; exp_wr[i] = 15;
        chk_da[i] = 1'b0; chk_cur[i] = 1'b0;
    endtask

    // One write occupies 5 frames; the strobe is low in frames 2 and 3.
    task automatic sched_write(input int s, input int chip, input int a, input int d);
        for (int k = 0; k < 5; k++) set_busy(s + k);
        for (int k = 2; k < 4; k++) begin
            exp_wr[s + k] = 15 & ~(1 << chip);
            chk_da[s + k] = 1'b1;
            exp_d[s + k]  = d;
            exp_a[s + k]  = a;
        end
    endtask

    task automatic sched_ready(input int s, input int cur);
        set_idle(s);
        chk_cur[s] = 1'b1;
        exp_cur[s] = cur;
    endtask

    task automatic sched_clear(input int s);
        for (int j = 0; j < 16; j++) sched_write(s + 5 * j, j / 4, 3 - (j % 4), 32);
        m_cursor = 0;
        sched_ready(s + 80, 0);
    endtask

    task automatic model_edge();
        int b;
        int code;
        f++;
        acc_flag = 1'b0;
        if (f > MAXF - 120) begin
            $display("FAIL frame_budget: frame %0d exceeds %0d", f, MAXF - 120);
            $fatal(1);
        end
        if (RST_i) begin
            for (int i = f; i <= f + 100; i++) set_idle(i);
            exp_ready[f] = 0; exp_busy[f] = 0;
            chk_da[f] = 1'b1; exp_d[f] = 32; exp_a[f] = 0;
            chk_cur[f] = 1'b1; exp_cur[f] = 0;
            m_cursor = 0;
            pend_clear = 1'b1;
        end else if (pend_clear) begin
            pend_clear = 1'b0;
            sched_clear(f);
        end else if (char_valid_i && exp_ready[f-1] == 1) begin
            acc_flag = 1'b1;
            b = int'(char_i);
            if (b >= 32) begin
                if (b >= 128)     code = 63;
                else if (b >= 96) code = b - 32;
                else              code = b;
                sched_write(f, m_cursor / 4, 3 - (m_cursor % 4), code);
                m_cursor = (m_cursor + 1) % 16;
                sched_ready(f + 5, m_cursor);
            end else begin
                set_busy(f);
                if (b == 13) begin
                    m_cursor = 0;
                    sched_ready(f + 1, m_cursor);
                end else if (b == 8) begin
                    m_cursor = (m_cursor + 15) % 16;
                    sched_ready(f + 1, m_cursor);
                end else if (b == 12) begin
                    sched_clear(f + 1);
                end else begin
                    sched_ready(f + 1, m_cursor);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s frame=%0d got=%0h want=%0h", name, f, act, exp);
        end
    endtask

    task automatic compare();
        chk("ready", 32'(char_ready_o), 32'(exp_ready[f]));
        chk("busy",  32'(busy_o),       32'(exp_busy[f]));
        chk("wr_n",  32'(hpdl_wr_n_o),  32'(exp_wr[f]));
        if (chk_da[f]) begin
            chk("data", 32'(hpdl_d_o), 32'(exp_d[f]));
            chk("addr", 32'(hpdl_a_o), 32'(exp_a[f]));
        end
        if (chk_cur[f]) chk("cursor", 32'(cursor_o), 32'(exp_cur[f]));
    endtask

    task automatic step();
        @(posedge CLK_i);
        model_edge();
        #1;
        compare();
    endtask

    task automatic send(input logic [7:0] b, input bit keep);
        int n;
        char_i = b;
        char_valid_i = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc_flag && n < 300);
        if (!acc_flag) chk("accept_timeout", 32'(0), 32'(1));
        if (!keep) char_valid_i = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [7:0] rb;
        int cat;
        for (int i = 0; i < MAXF; i++) set_idle(i);

        // Power-up clear: 16 space writes, chip0 A=3 first.
        steps(3);
        RST_i = 1'b0;
        steps(3);
        chk("pin_clr_wr", 32'(hpdl_wr_n_o), 32'(4'b1110));
        chk("pin_clr_a",  32'(hpdl_a_o),    32'(2'd3));
        chk("pin_clr_d",  32'(hpdl_d_o),    32'(7'h20));
        steps(78);
        chk("pin_clr_rdy", 32'(char_ready_o), 32'(1'b1));
        chk("pin_clr_cur", 32'(cursor_o),     32'(4'd0));

        send(8'h48, 1'b0);
        steps(2);
        chk("pin_H_wr", 32'(hpdl_wr_n_o), 32'(4'b1110));
        chk("pin_H_a",  32'(hpdl_a_o),    32'(2'd3));
        chk("pin_H_d",  32'(hpdl_d_o),    32'(7'h48));
        steps(3);
        chk("pin_H_rdy", 32'(char_ready_o), 32'(1'b1));
        chk("pin_H_cur", 32'(cursor_o),     32'(4'd1));

        send(8'h78, 1'b0); send(8'h79, 1'b0); send(8'h7A, 1'b0); send(8'h77, 1'b0);
        send(8'h61, 1'b0);
        steps(2);
        chk("pin_a_wr", 32'(hpdl_wr_n_o), 32'(4'b1101));
        chk("pin_a_a",  32'(hpdl_a_o),    32'(2'd2));
        chk("pin_a_d",  32'(hpdl_d_o),    32'(7'h41));
        send(8'hC3, 1'b0);
        steps(2);
        chk("pin_hi_d", 32'(hpdl_d_o), 32'(7'h3F));
        chk("pin_hi_a", 32'(hpdl_a_o), 32'(2'd1));
        send(8'h0D, 1'b0);

        // 'A'..'P' with valid held high between bytes.
        for (int i = 0; i < 16; i++) send(8'(8'h41 + i), (i < 15));
        steps(2);
        chk("pin_P_wr", 32'(hpdl_wr_n_o), 32'(4'b0111));
        chk("pin_P_a",  32'(hpdl_a_o),    32'(2'd0));
        steps(3);
        chk("pin_wrap_cur", 32'(cursor_o), 32'(4'd0));

        for (int i = 0; i < 9; i++) send(8'(8'h30 + i), 1'b0);
        send(8'h0D, 1'b0);
        step();
        chk("pin_cr_cur", 32'(cursor_o), 32'(4'd0));
        send(8'h08, 1'b0);
        step();
        chk("pin_bs_cur", 32'(cursor_o), 32'(4'd15));
        send(8'h0A, 1'b0);
        step();
        chk("pin_lf_cur", 32'(cursor_o), 32'(4'd15));
        send(8'h0C, 1'b0);
        steps(81);
        chk("pin_ff_rdy", 32'(char_ready_o), 32'(1'b1));
        chk("pin_ff_cur", 32'(cursor_o),     32'(4'd0));

        for (int n = 0; n < 150; n++) begin
            cat = $urandom_range(0, 19);
            if (cat == 0)      rb = 8'h0C;
            else if (cat == 1) rb = 8'h0D;
            else if (cat == 2) rb = 8'h08;
            else if (cat == 3) rb = 8'($urandom_range(0, 31));
            else if (cat < 6)  rb = 8'($urandom_range(128, 255));
            else if (cat < 10) rb = 8'($urandom_range(96, 127));
            else               rb = 8'($urandom_range(32, 95));
            send(rb, ($urandom_range(0, 1) == 0));
            if ($urandom_range(0, 2) == 0) begin
                char_valid_i = 1'b0;
                steps($urandom_range(0, 3));
            end
        end
        char_valid_i = 1'b0;
        steps(90);

        // Reset during the write pulse must release WR on the next edge.
        send(8'h5A, 1'b0);
        steps(2);
        RST_i = 1'b1;
        step();
        chk("pin_rst_wr",   32'(hpdl_wr_n_o),  32'(4'b1111));
        chk("pin_rst_busy", 32'(busy_o),       32'(1'b0));
        chk("pin_rst_cur",  32'(cursor_o),     32'(4'd0));
        chk("pin_rst_d",    32'(hpdl_d_o),     32'(7'h20));
        step();
        RST_i = 1'b0;
        steps(81);
        chk("pin_reclr_rdy", 32'(char_ready_o), 32'(1'b1));
        chk("pin_reclr_cur", 32'(cursor_o),     32'(4'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
